iir_out_buf: RTL and testbench

Output buffer directly downstream of the `iir` filter stage. It captures the filter's 32-bit signed `y` stream on every qualified cycle and narrows each sample to `OUT_W` bits. Samples are held in a first-word-fall-through FIFO and presented to the consumer over a valid/ready handshake. The filter cannot stall, so the block never back-pressures its input: it drops samples on overflow and records the event in a sticky flag.

---
 rtl/iir_out_buf.sv | 112 +++++++++++
 tb/tb_iir_out_buf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iir_out_buf.sv
// Output buffer for the iir filter stage: narrows each y sample to OUT_W bits and queues it in a FWFT FIFO.
// Optional macro IIR_OUT_SAT_EN selects signed saturation; otherwise samples are truncated.
module iir_out_buf #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sat_flag,
  output logic                     drop_flag,
  input  logic                     clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;
  logic                 ovf_c;
  logic [IN_W-OUT_W:0]  hi_c;
  logic [OUT_W-1:0]     narrow_c;

  assign full_c    = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop_c     = out_valid && out_ready;
  assign push_c    = in_valid && (!full_c || pop_c);
  assign drop_c    = in_valid && full_c && !pop_c;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Sample fits in OUT_W bits only when all discarded bits equal the new sign bit.
  assign hi_c  = in_data[IN_W-1:OUT_W-1];
  assign ovf_c = !((&hi_c) || !(|hi_c));

`ifdef IIR_OUT_SAT_EN
  logic sat_c;

  always_comb begin
    narrow_c = in_data[OUT_W-1:0];
    if (ovf_c) begin
      narrow_c = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign sat_c = push_c && ovf_c;

  // Sticky clamp flag; a set event in the same cycle overrides clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= sat_c || (sat_flag && !clr);
    end
  end
`else
  logic unused_ovf;

  assign narrow_c   = in_data[OUT_W-1:0];
  assign sat_flag   = 1'b0;
  assign unused_ovf = ovf_c;
`endif

  // Sticky overflow flag; a set event in the same cycle overrides clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_flag <= 1'b0;
    end else begin
      drop_flag <= drop_c || (drop_flag && !clr);
    end
  end

  // Pointers and occupancy; simultaneous push and pop hold count, even when full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage array needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= narrow_c;
    end
  end

endmodule

// File: tb/tb_iir_out_buf.sv
// Scoreboard bench for iir_out_buf with OUT_W=8, DEPTH=8; expectations follow IIR_OUT_SAT_EN when defined.
module tb_iir_out_buf;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned DEPTH = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [3:0]        count;
  logic              sat_flag;
  logic              drop_flag;
  logic              clr;

  int n_tests;
  int n_fail;
  int exp_q[$];

`ifdef IIR_OUT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  iir_out_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .sat_flag  (sat_flag),
    .drop_flag (drop_flag),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
      end else begin
        check("out_data", int'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with a sample offered; stored samples record their expected narrowed value.
  task automatic offer(input int d, input bit rdy, input bit stored, input int exp);
    in_valid  = 1'b1;
    in_data   = IN_W'(d);
    out_ready = rdy;
    if (stored) exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    out_ready = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #2;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sat", int'(sat_flag), 0);
    check("rst_drop", int'(drop_flag), 0);
    step();
    reset = 1'b1;
    step();
    step();

    // Ordering
    offer(6, 1'b0, 1'b1, 6);
    offer(-11, 1'b0, 1'b1, -11);
    offer(48, 1'b0, 1'b1, 48);
    offer(-128, 1'b0, 1'b1, -128);
    check("ord_count", int'(count), 4);
    check("ord_head", int'($signed(out_data)), 6);
    check("ord_valid", int'(out_valid), 1);
    drain(4);
    check("ord_empty_valid", int'(out_valid), 0);
    check("ord_empty_data", int'(out_data), 0);
    check("ord_sat", int'(sat_flag), 0);

    // Narrowing
    offer(408, 1'b0, 1'b1, SAT ? 127 : -104);
    offer(-300, 1'b0, 1'b1, SAT ? -128 : -44);
    check("nar_sat", int'(sat_flag), SAT ? 1 : 0);
    offer(-128, 1'b0, 1'b1, -128);
    check("nar_sat_hold", int'(sat_flag), SAT ? 1 : 0);
    check("nar_count", int'(count), 3);
    drain(3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_sat", int'(sat_flag), 0);
    check("clr_drop", int'(drop_flag), 0);

    // Full, drop, push-while-full-with-pop
    for (int i = 1; i <= 8; i++) offer(i, 1'b0, 1'b1, i);
    check("full_count", int'(count), 8);
    check("full_drop_pre", int'(drop_flag), 0);
    offer(9, 1'b0, 1'b0, 0);
    check("drop_count", int'(count), 8);
    check("drop_flag", int'(drop_flag), 1);
    offer(10, 1'b1, 1'b1, 10);
    check("fullpop_count", int'(count), 8);
    drain(8);
    check("full_drained", int'(out_valid), 0);

    // Flags: clr alone, then clr coincident with a drop
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr2_drop", int'(drop_flag), 0);
    for (int i = 0; i < 8; i++) offer(20 + i, 1'b0, 1'b1, 20 + i);
    clr = 1'b1;
    offer(99, 1'b0, 1'b0, 0);
    clr = 1'b0;
    check("clr_vs_drop", int'(drop_flag), 1);
    drain(8);

    // Wrap-around at steady occupancy of one
    offer(100, 1'b0, 1'b1, 100);
    for (int i = 1; i <= 20; i++) offer(100 + i, 1'b1, 1'b1, 100 + i);
    check("wrap_count", int'(count), 1);
    drain(1);
    check("wrap_empty", int'(count), 0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) offer(-5 - i, 1'b0, 1'b1, -5 - i);
    check("pre_rst_count", int'(count), 3);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_drop", int'(drop_flag), 0);
    check("mid_rst_sat", int'(sat_flag), 0);
    step();
    reset = 1'b1;
    step();
    offer(77, 1'b0, 1'b1, 77);
    check("post_rst_count", int'(count), 1);
    drain(1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
